// File: rtl/multicycle_control.sv
// Multi-cycle LEGv8 sequencing control: a Moore FSM stepping fetch/decode/execute/memory/writeback,
// with a variable-latency memory handshake, illegal-opcode and memory-timeout trapping, and a retire counter.
module multicycle_control #(
    parameter int OPCODE_LEN  = 11,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [OPCODE_LEN-1:0] opcode,
    input  logic                  mem_ready,
    input  logic                  zero,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  pc_write_cond,
    output logic                  branch_nonzero,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  mem_to_reg,
    output logic                  reg_write,
    output logic                  readreg2_control,
    output logic                  alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            alu_op,
    output logic                  pc_source,
    output logic                  instr_done,
    output logic                  illegal,
    output logic                  mem_timeout,
    output logic [CNT_W-1:0]      retired,
    output logic [3:0]            state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WR   = 4'd4,
        S_LD_WB    = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_CBRANCH  = 4'd8,
        S_UBRANCH  = 4'd9,
        S_ERROR    = 4'd10
    } state_e;

    typedef enum logic [2:0] {
        OP_LDUR    = 3'd0,
        OP_STUR    = 3'd1,
        OP_RTYPE   = 3'd2,
        OP_CBR     = 3'd3,
        OP_UBR     = 3'd4,
        OP_ILLEGAL = 3'd5
    } op_class_e;

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_nonzero;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       readreg2_control;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       pc_source;
        logic       instr_done;
    } ctrl_t;

    localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    // Classify the opcode; x positions in the encodings are don't-care.
    function automatic op_class_e decode_op(input logic [10:0] op);
        op_class_e cls;
        casez (op)
            11'b11111000010: cls = OP_LDUR;
            11'b11111000000: cls = OP_STUR;
            11'b10001011000: cls = OP_RTYPE;
            11'b11001011000: cls = OP_RTYPE;
            11'b10001010000: cls = OP_RTYPE;
            11'b10101010000: cls = OP_RTYPE;
            11'b10110100???: cls = OP_CBR;
            11'b10110101???: cls = OP_CBR;
            11'b000101?????: cls = OP_UBR;
            default:         cls = OP_ILLEGAL;
        endcase
        return cls;
    endfunction

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              illegal_q, illegal_d;
    logic              mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0]  retired_q, retired_d;

    op_class_e op_class_s;
    logic      in_wait_s;
    logic      timeout_s;
    ctrl_t     ctrl_s;
    ctrl_t     ctrl_o_s;

    assign op_class_s = decode_op(opcode[10:0]);
    assign in_wait_s  = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    // A ready arriving in the timeout cycle wins, so timeout only fires while mem_ready is low.
    assign timeout_s  = (MEM_TIMEOUT != 0) && in_wait_s && !mem_ready && (wait_q == WAIT_MAX);

    // State, wait counter, sticky flags and retire counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_FETCH;
            wait_q        <= '0;
            illegal_q     <= 1'b0;
            mem_timeout_q <= 1'b0;
            retired_q     <= '0;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            illegal_q     <= illegal_d;
            mem_timeout_q <= mem_timeout_d;
            retired_q     <= retired_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (reset) begin
            state_d = S_FETCH;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (mem_ready)      state_d = S_DECODE;
                    else if (timeout_s) state_d = S_ERROR;
                    else                state_d = S_FETCH;
                end
                S_DECODE: begin
                    case (op_class_s)
                        OP_LDUR:  state_d = S_MEM_ADDR;
                        OP_STUR:  state_d = S_MEM_ADDR;
                        OP_RTYPE: state_d = S_R_EXEC;
                        OP_CBR:   state_d = S_CBRANCH;
                        OP_UBR:   state_d = S_UBRANCH;
                        default:  state_d = S_ERROR;
                    endcase
                end
                S_MEM_ADDR: begin
                    if (op_class_s == OP_STUR) state_d = S_MEM_WR;
                    else                       state_d = S_MEM_RD;
                end
                S_MEM_RD: begin
                    if (mem_ready)      state_d = S_LD_WB;
                    else if (timeout_s) state_d = S_ERROR;
                    else                state_d = S_MEM_RD;
                end
                S_MEM_WR: begin
                    if (mem_ready)      state_d = S_FETCH;
                    else if (timeout_s) state_d = S_ERROR;
                    else                state_d = S_MEM_WR;
                end
                S_LD_WB:   state_d = S_FETCH;
                S_R_EXEC:  state_d = S_R_WB;
                S_R_WB:    state_d = S_FETCH;
                S_CBRANCH: state_d = S_FETCH;
                S_UBRANCH: state_d = S_FETCH;
                S_ERROR:   state_d = S_ERROR;
                default:   state_d = S_ERROR;
            endcase
        end
    end

    // Wait counter restarts on every state change, counts not-ready cycles and saturates at the limit.
    always_comb begin
        wait_d = wait_q;
        if (state_d != state_q) begin
            wait_d = '0;
        end else if (in_wait_s && !mem_ready && (wait_q != WAIT_MAX)) begin
            wait_d = wait_q + WAIT_W'(1);
        end else begin
            wait_d = wait_q;
        end
    end

    // Sticky error flags and retired-instruction count.
    always_comb begin
        illegal_d     = illegal_q;
        mem_timeout_d = mem_timeout_q;
        if ((state_q == S_DECODE) && (state_d == S_ERROR)) begin
            illegal_d = 1'b1;
        end else begin
            illegal_d = illegal_q;
        end
        if (in_wait_s && (state_d == S_ERROR)) begin
            mem_timeout_d = 1'b1;
        end else begin
            mem_timeout_d = mem_timeout_q;
        end
        retired_d = retired_q + CNT_W'(ctrl_o_s.instr_done);
    end

    // Per-state datapath strobes; only the fetch/wait handshakes look at mem_ready.
    always_comb begin
        ctrl_s = '0;
        case (state_q)
            S_FETCH: begin
                ctrl_s.mem_read  = 1'b1;
                ctrl_s.alu_src_a = 1'b0;
                ctrl_s.alu_src_b = 2'b01;
                ctrl_s.alu_op    = 2'b00;
                ctrl_s.ir_write  = mem_ready;
                ctrl_s.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl_s.alu_src_a        = 1'b0;
                ctrl_s.alu_src_b        = 2'b11;
                ctrl_s.alu_op           = 2'b00;
                ctrl_s.readreg2_control = (op_class_s == OP_STUR) || (op_class_s == OP_CBR);
            end
            S_MEM_ADDR: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.alu_src_b = 2'b10;
                ctrl_s.alu_op    = 2'b00;
            end
            S_MEM_RD: begin
                ctrl_s.mem_read = 1'b1;
            end
            S_MEM_WR: begin
                ctrl_s.mem_write        = 1'b1;
                ctrl_s.readreg2_control = 1'b1;
                ctrl_s.instr_done       = mem_ready;
            end
            S_LD_WB: begin
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.mem_to_reg = 1'b1;
                ctrl_s.instr_done = 1'b1;
            end
            S_R_EXEC: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.alu_src_b = 2'b00;
                ctrl_s.alu_op    = 2'b10;
            end
            S_R_WB: begin
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.mem_to_reg = 1'b0;
                ctrl_s.instr_done = 1'b1;
            end
            S_CBRANCH: begin
                ctrl_s.alu_src_a        = 1'b1;
                ctrl_s.alu_src_b        = 2'b00;
                ctrl_s.alu_op           = 2'b01;
                ctrl_s.readreg2_control = 1'b1;
                ctrl_s.pc_write_cond    = 1'b1;
                ctrl_s.pc_source        = 1'b1;
                ctrl_s.branch_nonzero   = opcode[3];
                ctrl_s.instr_done       = 1'b1;
            end
            S_UBRANCH: begin
                ctrl_s.pc_write   = 1'b1;
                ctrl_s.pc_source  = 1'b1;
                ctrl_s.instr_done = 1'b1;
            end
            S_ERROR: begin
                ctrl_s = '0;
            end
            default: begin
                ctrl_s = '0;
            end
        endcase
    end

    // Reset silences every strobe in the cycle it is held, including an in-flight instr_done.
    always_comb begin
        if (reset) ctrl_o_s = '0;
        else       ctrl_o_s = ctrl_s;
    end

    // The zero flag is consumed by the datapath's branch gate, not by the sequencer.
    logic unused_s;
    assign unused_s = zero;

    assign ir_write         = ctrl_o_s.ir_write;
    assign pc_write         = ctrl_o_s.pc_write;
    assign pc_write_cond    = ctrl_o_s.pc_write_cond;
    assign branch_nonzero   = ctrl_o_s.branch_nonzero;
    assign mem_read         = ctrl_o_s.mem_read;
    assign mem_write        = ctrl_o_s.mem_write;
    assign mem_to_reg       = ctrl_o_s.mem_to_reg;
    assign reg_write        = ctrl_o_s.reg_write;
    assign readreg2_control = ctrl_o_s.readreg2_control;
    assign alu_src_a        = ctrl_o_s.alu_src_a;
    assign alu_src_b        = ctrl_o_s.alu_src_b;
    assign alu_op           = ctrl_o_s.alu_op;
    assign pc_source        = ctrl_o_s.pc_source;
    assign instr_done       = ctrl_o_s.instr_done;
    assign illegal          = illegal_q;
    assign mem_timeout      = mem_timeout_q;
    assign retired          = retired_q;
    assign state            = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: instruction state traces, memory waits, traps, reset abort
// and retire-counter wrap, with hand-computed expectations.
module tb_multicycle_control;

    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100111;
    localparam logic [10:0] OP_CBNZ = 11'b10110101000;
    localparam logic [10:0] OP_B    = 11'b00010100000;

    logic        clk;
    logic        reset;
    logic [10:0] opcode;
    logic        mem_ready;
    logic        zero;
    logic        ir_write, pc_write, pc_write_cond, branch_nonzero;
    logic        mem_read, mem_write, mem_to_reg, reg_write, readreg2_control;
    logic        alu_src_a;
    logic [1:0]  alu_src_b, alu_op;
    logic        pc_source, instr_done, illegal, mem_timeout;
    logic [3:0]  retired;
    logic [3:0]  state;
    logic [15:0] strobes;

    int          checks;
    int          failures;
    logic [3:0]  exp_ret;
    int          cyc, mr_cnt, rw_cnt, rw_state, rd_waits;
    logic        seen_done;

    multicycle_control #(.OPCODE_LEN(11), .MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
        .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .branch_nonzero(branch_nonzero), .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .readreg2_control(readreg2_control),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
        .instr_done(instr_done), .illegal(illegal), .mem_timeout(mem_timeout),
        .retired(retired), .state(state)
    );

    assign strobes = {ir_write, pc_write, pc_write_cond, branch_nonzero, mem_read, mem_write,
                      mem_to_reg, reg_write, readreg2_control, alu_src_a, alu_src_b, alu_op,
                      pc_source, instr_done};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        adv();
        reset = 1'b0;
        #1;
        exp_ret = 4'd0;
    endtask

    // Runs one instruction from FETCH with zero-wait memory; tr holds n expected states as nibbles.
    task automatic run_trace(input string tag, input logic [10:0] op, input int n, input logic [19:0] tr);
        opcode    = op;
        mem_ready = 1'b1;
        #1;
        for (int i = 0; i < n; i++) begin
            chk({tag, "_state"}, 32'(state), 32'(tr[4*(n-1-i) +: 4]));
            chk({tag, "_done"}, 32'(instr_done), 32'(i == n - 1));
            adv();
        end
        exp_ret = exp_ret + 4'd1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        exp_ret   = 4'd0;
        reset     = 1'b1;
        mem_ready = 1'b0;
        opcode    = 11'd0;
        zero      = 1'b0;
        adv();
        adv();

        // Reset held: strobes silenced even with mem_ready high.
        mem_ready = 1'b1;
        #1;
        chk("rst_strobes", 32'(strobes), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        chk("rst_flags", 32'({illegal, mem_timeout}), 32'd0);

        // First cycle after reset: FETCH outputs live.
        reset = 1'b0;
        #1;
        chk("fetch_mem_read", 32'(mem_read), 32'd1);
        chk("fetch_ir_pc_write", 32'({ir_write, pc_write}), 32'h3);
        chk("fetch_alu", 32'({alu_src_a, alu_src_b, alu_op}), 32'b0_01_00);

        // Zero-wait traces.
        run_trace("ldur", OP_LDUR, 5, 20'h01235);
        run_trace("add",  OP_ADD,  4, 20'h00167);
        run_trace("stur", OP_STUR, 4, 20'h00124);
        run_trace("cbz",  OP_CBZ,  3, 20'h00018);
        run_trace("b",    OP_B,    3, 20'h00019);
        chk("retired_after5", 32'(retired), 32'd5);
        run_trace("sub",  OP_SUB,  4, 20'h00167);
        run_trace("and",  OP_AND,  4, 20'h00167);
        run_trace("orr",  OP_ORR,  4, 20'h00167);
        chk("retired_after8", 32'(retired), 32'(exp_ret));

        // LDUR with three not-ready cycles in MEM_RD.
        opcode   = OP_LDUR;
        cyc      = 0;
        mr_cnt   = 0;
        rw_cnt   = 0;
        rw_state = -1;
        rd_waits = 0;
        seen_done = 1'b0;
        while (!seen_done && cyc < 20) begin
            if (state == 4'd3 && rd_waits < 3) begin
                mem_ready = 1'b0;
                rd_waits++;
            end else begin
                mem_ready = 1'b1;
            end
            #1;
            if (mem_read) mr_cnt++;
            if (reg_write) begin
                rw_cnt++;
                rw_state = int'(state);
            end
            seen_done = instr_done;
            cyc++;
            adv();
        end
        exp_ret = exp_ret + 4'd1;
        chk("ldwait_done_seen", 32'(seen_done), 32'd1);
        chk("ldwait_cycles", 32'(cyc), 32'd8);
        chk("ldwait_mem_read_cycles", 32'(mr_cnt), 32'd5);
        chk("ldwait_reg_write_cycles", 32'(rw_cnt), 32'd1);
        chk("ldwait_reg_write_state", 32'(rw_state), 32'd5);
        chk("ldwait_retired", 32'(retired), 32'(exp_ret));

        // CBNZ.
        opcode    = OP_CBNZ;
        mem_ready = 1'b1;
        #1;
        chk("cbnz_fetch", 32'(state), 32'd0);
        adv();
        chk("cbnz_decode", 32'(state), 32'd1);
        chk("cbnz_decode_rr2", 32'(readreg2_control), 32'd1);
        chk("cbnz_decode_srcb", 32'(alu_src_b), 32'd3);
        adv();
        chk("cbnz_state", 32'(state), 32'd8);
        chk("cbnz_bnz", 32'(branch_nonzero), 32'd1);
        chk("cbnz_pwc_pw", 32'({pc_write_cond, pc_write}), 32'b10);
        chk("cbnz_alu_op", 32'(alu_op), 32'd1);
        chk("cbnz_pc_src_done", 32'({pc_source, instr_done}), 32'b11);
        adv();
        exp_ret = exp_ret + 4'd1;

        // Illegal opcode traps after DECODE and holds.
        opcode = 11'd0;
        #1;
        chk("ill_fetch", 32'(state), 32'd0);
        adv();
        chk("ill_decode", 32'(state), 32'd1);
        adv();
        chk("ill_state", 32'(state), 32'd10);
        chk("ill_flags", 32'({illegal, mem_timeout}), 32'b10);
        for (int i = 0; i < 10; i++) begin
            mem_ready = i[0];
            adv();
            chk("ill_hold_strobes", 32'(strobes), 32'd0);
            chk("ill_hold_state", 32'(state), 32'd10);
            chk("ill_sticky", 32'(illegal), 32'd1);
            chk("ill_retired", 32'(retired), 32'(exp_ret));
        end
        do_reset();
        chk("ill_cleared", 32'({illegal, state}), 32'd0);
        chk("ill_rst_retired", 32'(retired), 32'd0);

        // Fetch timeout with mem_ready tied low.
        mem_ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("to_fetch_state", 32'(state), 32'd0);
            adv();
        end
        chk("to_error_state", 32'(state), 32'd10);
        chk("to_flags", 32'({illegal, mem_timeout}), 32'b01);
        do_reset();

        // Ready arriving in the timeout cycle wins.
        mem_ready = 1'b0;
        opcode    = OP_B;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("to2_fetch_state", 32'(state), 32'd0);
            adv();
        end
        mem_ready = 1'b1;
        #1;
        chk("to2_ir_write", 32'({state, ir_write}), 32'b0000_1);
        adv();
        chk("to2_decode", 32'(state), 32'd1);
        adv();
        chk("to2_ubranch", 32'(state), 32'd9);
        adv();
        exp_ret = exp_ret + 4'd1;
        chk("to2_retired", 32'(retired), 32'(exp_ret));

        // Reset pulsed during MEM_WR aborts without retiring.
        do_reset();
        opcode    = OP_STUR;
        mem_ready = 1'b1;
        adv();
        adv();
        adv();
        mem_ready = 1'b0;
        #1;
        chk("mw_state", 32'(state), 32'd4);
        chk("mw_strobes", 32'({mem_write, readreg2_control, instr_done}), 32'b110);
        adv();
        reset     = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk("mw_rst_strobes", 32'({mem_write, instr_done}), 32'b00);
        adv();
        reset = 1'b0;
        #1;
        chk("mw_after_state", 32'(state), 32'd0);
        chk("mw_after_retired", 32'(retired), 32'd0);
        chk("mw_after_fetch", 32'(mem_read), 32'd1);

        // Retire counter wraps modulo 16.
        opcode    = OP_B;
        mem_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            adv();
            adv();
            adv();
            if (k == 14) chk("wrap_15", 32'(retired), 32'd15);
        end
        chk("wrap_0", 32'(retired), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Sequencing control unit for the multi-cycle LEGv8 datapath, the successor to the single-cycle combinational `control` decoder. It takes the 11-bit opcode from the instruction register and steps a Moore FSM through fetch, decode, execute, memory and writeback. Each step drives per-state datapath strobes. It handshakes with a variable-latency memory, detects illegal opcodes and memory timeouts, and counts retired instructions. It sits beside the datapath and replaces `control` in the multi-cycle build.

## Interface
- `OPCODE_LEN`, 11: opcode width (instruction[31:21]).
- `MEM_TIMEOUT`, 16: maximum wait cycles for `mem_ready` per access; 0 disables the timeout.
- `CNT_W`, 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `opcode`  in  OPCODE_LEN  instruction register bits [31:21], valid from DECODE onward.
- `mem_ready`  in  1  memory completes the current read/write this cycle.
- `zero`  in  1  ALU zero flag.
- `ir_write`, `pc_write`  out  1  latch the instruction register / update the PC unconditionally.
- `pc_write_cond`  out  1  update the PC if the branch condition holds.
- `branch_nonzero`  out  1  condition is `!zero` (CBNZ), else `zero`.
- `mem_read`, `mem_write`, `mem_to_reg`, `reg_write`, `readreg2_control`  out  1  same meaning as in `control`.
- `alu_src_a`  out  1  0=PC, 1=register A.
- `alu_src_b`  out  2  00=register B, 01=constant 4, 10=sign-extended immediate, 11=branch offset<<2.
- `alu_op`  out  2  00=add, 01=pass B, 10=funct decode.
- `pc_source`  out  1  0=ALU result, 1=ALUOut.
- `instr_done`  out  1  one-cycle pulse on the final cycle of each instruction.
- `illegal`, `mem_timeout`  out  1  sticky error flags.
- `retired`  out  CNT_W  count of completed instructions.
- `state`  out  4  current state encoding, for debug.

## Operation
- The FSM is Moore. The state encoding is as listed: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WR=4, LD_WB=5, R_EXEC=6, R_WB=7, CBRANCH=8, UBRANCH=9, ERROR=10.
- Opcode decoding, with x bits ignored:
  - LDUR 11111000010; STUR 11111000000.
  - R-type ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000.
  - CBZ 10110100xxx; CBNZ 10110101xxx; B 000101xxxxx.
  - Any other opcode is illegal.
- FETCH:
  - Drives `mem_read`=1, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00.
  - `ir_write` and `pc_write` are asserted only in a cycle where `mem_ready`=1; the FSM then moves to DECODE. Otherwise it stays in FETCH.
- DECODE:
  - Drives `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00 (branch target into ALUOut).
  - `readreg2_control`=1 for STUR, CBZ and CBNZ.
  - Next state: LDUR/STUR→MEM_ADDR, R-type→R_EXEC, CB→CBRANCH, B→UBRANCH, illegal→ERROR.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Next state is MEM_RD for LDUR, MEM_WR for STUR.
- MEM_RD: `mem_read`=1 held until `mem_ready`, then LD_WB.
- MEM_WR: `mem_write`=1, `readreg2_control`=1, held until `mem_ready`. On `mem_ready` it pulses `instr_done` and goes to FETCH.
- LD_WB: `reg_write`=1, `mem_to_reg`=1, `instr_done`=1, then FETCH.
- R_EXEC: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10, then R_WB.
- R_WB: `reg_write`=1, `mem_to_reg`=0, `instr_done`=1, then FETCH.
- CBRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `readreg2_control`=1, `pc_write_cond`=1, `pc_source`=1. `branch_nonzero`=opcode[3]. Pulses `instr_done`, then FETCH.
- UBRANCH: `pc_write`=1, `pc_source`=1, `instr_done`=1, then FETCH.
- ERROR:
  - All strobes are 0 and the state is held until `reset`.
  - `illegal` is set on entry from DECODE; `mem_timeout` is set on entry from a wait state.
- Any output not listed for a state is 0 in that state.
- `retired` increments by 1 on every `instr_done` cycle and wraps modulo 2^CNT_W.

## Timing
- While `reset` is high, the next state is FETCH, `retired`, `illegal` and `mem_timeout` are cleared, and all strobes are forced to 0 that cycle.
- In the first cycle after `reset` falls, the FETCH outputs are active.
- Latency with zero-wait memory (`mem_ready` high on first request):
  - R-type: 4 cycles.
  - LDUR: 5 cycles.
  - STUR: 4 cycles.
  - CBZ/CBNZ/B: 3 cycles.
- Each wait cycle adds one cycle to that access.
- The wait counter:
  - Resets to 0 on entry to FETCH, MEM_RD or MEM_WR.
  - Increments each cycle `mem_ready`=0.
  - Reaching MEM_TIMEOUT moves the FSM to ERROR on the next edge; `mem_ready` arriving in that same cycle takes priority and completes the access normally.
- `mem_ready` asserted outside FETCH, MEM_RD or MEM_WR is ignored.
- `reset` asserted mid-instruction aborts the instruction with no `instr_done`; FETCH follows.
- `instr_done` is never high for 2 consecutive cycles.

## Test plan
- Zero-wait sequence, IR opcodes taken from F84402C9 (LDUR), 8B09026A (ADD), F80602CB (STUR), B4FFFF6B (CBZ), 14000040 (B) -> `state` traces 0,1,2,3,5 / 0,1,6,7 / 0,1,2,4 / 0,1,8 / 0,1,9; `retired`=5 afterwards.
- LDUR with `mem_ready` low for 3 cycles in MEM_RD -> `mem_read` held for 4 cycles, total instruction 8 cycles, `reg_write` asserted only in LD_WB.
- CBNZ opcode 10110101000 -> CBRANCH with `branch_nonzero`=1, `pc_write_cond`=1, `pc_write`=0, `alu_op`=01.
- Opcode 0x000 -> ERROR after DECODE; `illegal`=1 and sticky; all strobes 0 for 10 further cycles; `retired` unchanged.
- MEM_TIMEOUT=4, `mem_ready` tied low -> FETCH for 5 cycles then ERROR, `mem_timeout`=1. A second run with `mem_ready` high on the 5th FETCH cycle -> proceeds to DECODE.
- `reset` pulsed during MEM_WR -> `mem_write` low during reset, FETCH next, no `instr_done`, `retired` is 0.
